// File: rtl/audio_rms_calculator.sv
// Windowed RMS of a signed sample stream: sum of squares over 2^LOG2_WINDOW
// accepted samples, shift-divide, then a bit-serial restoring square root.
module audio_rms_calculator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int LOG2_WINDOW  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic                           sample_valid,
  output logic        [SAMPLE_WIDTH-1:0] signal_rms,
  output logic                           signal_rms_valid
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int L  = LOG2_WINDOW;
  localparam int AW = 2 * W + L;
  localparam int IW = $clog2(W);

  generate
    if (L < 5 || L > 12) begin : g_bad_window
      $error("LOG2_WINDOW must be in the range 5..12");
    end
  endgenerate

  typedef enum logic [1:0] {ACCUM, SQRT, OUT} state_t;

  state_t          state_reg;
  logic [AW-1:0]   acc_reg;
  logic [L-1:0]    cnt_reg;
  logic [2*W-1:0]  rad_reg;
  logic [W+1:0]    rem_reg;
  logic [W-1:0]    root_reg;
  logic [IW-1:0]   iter_reg;

  logic signed [2*W-1:0] prod;
  logic [2*W-1:0]        sq;
  logic [AW-1:0]         acc_next;
  logic [W+1:0]          rem_shift;
  logic [W+1:0]          trial;
  logic                  window_end;

  assign prod       = sample * sample;
  assign sq         = prod;
  assign acc_next   = acc_reg + AW'(sq);
  assign window_end = sample_valid && (cnt_reg == '1);

  // Before each step the remainder is below 2^W, so its top bits can be dropped.
  assign rem_shift = {rem_reg[W-1:0], rad_reg[2*W-1 -: 2]};
  assign trial     = {root_reg, 2'b01};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ACCUM;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      rad_reg          <= '0;
      rem_reg          <= '0;
      root_reg         <= '0;
      iter_reg         <= '0;
      signal_rms       <= '0;
      signal_rms_valid <= 1'b0;
    end else begin
      signal_rms_valid <= 1'b0;

      // Accumulation runs independently of the root FSM so no sample is lost.
      if (sample_valid) begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= window_end ? '0 : acc_next;
      end

      case (state_reg)
        ACCUM: begin
          if (window_end) begin
            rad_reg   <= acc_next[AW-1:L];
            rem_reg   <= '0;
            root_reg  <= '0;
            iter_reg  <= IW'(W - 1);
            state_reg <= SQRT;
          end
        end
        SQRT: begin
          rad_reg <= rad_reg << 2;
          if (rem_shift >= trial) begin
            rem_reg  <= rem_shift - trial;
            root_reg <= {root_reg[W-2:0], 1'b1};
          end else begin
            rem_reg  <= rem_shift;
            root_reg <= {root_reg[W-2:0], 1'b0};
          end
          if (iter_reg == '0) state_reg <= OUT;
          else                iter_reg  <= iter_reg - 1'b1;
        end
        OUT: begin
          signal_rms       <= root_reg;
          signal_rms_valid <= 1'b1;
          state_reg        <= ACCUM;
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  // A window of at least 32 samples always outlasts the root computation.
  always @(posedge clk) begin
    if (reset && window_end) begin
      a_window_end_in_accum: assert (state_reg == ACCUM);
    end
  end

endmodule

// File: tb/tb_audio_rms_calculator.sv
// Randomized bench for audio_rms_calculator: two instances (windows of 32 and
// 256) checked against a queue of expected RMS pulses computed with plain arithmetic.
module tb_audio_rms_calculator;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst_n;
  logic [1:0]          sv;
  logic signed [W-1:0] smp [2];
  logic [W-1:0]        rms [2];
  logic [1:0]          vld;

  audio_rms_calculator #(.SAMPLE_WIDTH(W), .LOG2_WINDOW(5)) dut0 (
    .clk              (clk),
    .reset            (rst_n[0]),
    .sample           (smp[0]),
    .sample_valid     (sv[0]),
    .signal_rms       (rms[0]),
    .signal_rms_valid (vld[0])
  );

  audio_rms_calculator #(.SAMPLE_WIDTH(W), .LOG2_WINDOW(8)) dut1 (
    .clk              (clk),
    .reset            (rst_n[1]),
    .sample           (smp[1]),
    .sample_valid     (sv[1]),
    .signal_rms       (rms[1]),
    .signal_rms_valid (vld[1])
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  longint      cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     d;
    longint val;
    longint due;
  } exp_t;

  exp_t   expq [$];
  longint model_rms [2];
  int     cnt_m [2];
  longint sum_m [2];
  int     log2w [2];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint isqrt(input longint m);
    longint r;
    r = longint'($floor($sqrt(real'(m))));
    while (r * r > m) r--;
    while ((r + 1) * (r + 1) <= m) r++;
    return r;
  endfunction

  // Output monitor: every pulse must match the oldest expectation, else hold.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld[d]) begin
        if (expq.size() > 0 && expq[0].d == d) begin
          exp_t e;
          e = expq.pop_front();
          $display("pulse dut=%0d rms=%0d expected=%0d cycle=%0d due=%0d",
                   d, rms[d], e.val, cyc, e.due);
          check("rms_value", longint'(rms[d]), e.val);
          check("pulse_cycle", cyc, e.due);
          model_rms[d] = e.val;
        end else begin
          check("spurious_valid", longint'(vld[d]), 0);
        end
      end else begin
        check("rms_hold", longint'(rms[d]), model_rms[d]);
      end
    end
  end

  task automatic clear_model(input int d);
    expq.delete();
    cnt_m[d]     = 0;
    sum_m[d]     = 0;
    model_rms[d] = 0;
  endtask

  // Drive one accepted sample after 'gap' idle cycles; the pulse is due 18
  // edges after the edge preceding acceptance (accept edge + 17).
  task automatic send(input int d, input logic signed [W-1:0] v, input int gap);
    exp_t e;
    repeat (gap) begin
      @(posedge clk); #1;
      sv[d] = 1'b0;
    end
    @(posedge clk); #1;
    smp[d] = v;
    sv[d]  = 1'b1;
    sum_m[d] += longint'(v) * longint'(v);
    cnt_m[d]++;
    if (cnt_m[d] == (1 << log2w[d])) begin
      e.d   = d;
      e.val = isqrt(sum_m[d] >>> log2w[d]);
      e.due = cyc + 18;
      expq.push_back(e);
      cnt_m[d] = 0;
      sum_m[d] = 0;
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sv[d] = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    int t;
    idle(d, 1);
    t = 0;
    while (expq.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (expq.size() > 0) begin
      check("pulse_timeout", longint'(expq.size()), 0);
      expq.delete();
    end
    idle(d, 3);
  endtask

  task automatic do_reset(input int d);
    @(posedge clk); #3;
    rst_n[d] = 1'b0;
    sv[d]    = 1'b0;
    clear_model(d);
    #1;
    check("reset_rms", longint'(rms[d]), 0);
    check("reset_valid", longint'(vld[d]), 0);
    repeat (3) @(posedge clk);
    #2 rst_n[d] = 1'b1;
    idle(d, 30);
  endtask

  task automatic send_window(input int d, input logic signed [W-1:0] a,
                             input logic signed [W-1:0] b, input int max_gap);
    for (int i = 0; i < (1 << log2w[d]); i++)
      send(d, (i % 2 == 0) ? a : b, int'($urandom_range(0, max_gap)));
  endtask

  initial begin
    log2w[0] = 5;
    log2w[1] = 8;
    rst_n    = 2'b00;
    sv       = 2'b00;
    smp[0]   = '0;
    smp[1]   = '0;
    clear_model(0);
    clear_model(1);
    repeat (2) @(posedge clk);
    #1;
    check("init_rms0", longint'(rms[0]), 0);
    check("init_valid0", longint'(vld[0]), 0);
    check("init_rms1", longint'(rms[1]), 0);
    check("init_valid1", longint'(vld[1]), 0);
    #1 rst_n = 2'b11;

    // Constant, alternating, silence, full scale and floor cases
    send_window(0, 16'sd1000, 16'sd1000, 2);     drain(0);
    send_window(0, 16'sd3000, -16'sd3000, 1);    drain(0);
    send_window(0, 16'sd0, 16'sd0, 1);           drain(0);
    send_window(0, -16'sd32768, -16'sd32768, 0); drain(0);
    send_window(0, 16'sd32767, 16'sd32767, 2);   drain(0);
    send_window(0, 16'sd3, 16'sd4, 1);           drain(0);
    send_window(0, 16'sd0, 16'sd10, 1);          drain(0);

    // Three back-to-back windows with no idle cycles
    send_window(0, 16'sd100, 16'sd100, 0);
    send_window(0, 16'sd200, 16'sd200, 0);
    send_window(0, 16'sd300, 16'sd300, 0);
    drain(0);

    // Reset mid-window, then mid-root; no pulse may survive either
    for (int i = 0; i < 20; i++) send(0, 16'sd5000, 0);
    do_reset(0);
    send_window(0, 16'sd5000, 16'sd5000, 0);
    idle(0, 6);
    do_reset(0);
    send_window(0, 16'sd50, 16'sd50, 1);         drain(0);

    // Randomized windows with random gaps
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++)
        send(0, W'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    end
    drain(0);

    // 256-sample window instance
    do_reset(1);
    send_window(1, 16'sd1234, 16'sd1234, 0);     drain(1);
    for (int i = 0; i < 256; i++)
      send(1, W'($urandom_range(0, 65535)), int'($urandom_range(0, 1)));
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
